// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: FSM state encoding,
// default widths, and a two's-complement magnitude helper.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Absolute value as an unsigned DIV_WIDTH-bit quantity; the most negative
  // input maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v);
    logic [DIV_WIDTH-1:0] res;
    if (v[DIV_WIDTH-1]) begin
      res = {DIV_WIDTH{1'b0}} - v;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor when it fits, and record the
// quotient bit in the vacated LSB of q.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  // The WIDTH+1 bit shifted value keeps the remainder's MSB so the compare is exact.
  logic [WIDTH:0] shifted_s;

  // Restoring step: trial-subtract and keep the result only when non-negative.
  always_comb begin
    shifted_s = {rem, q[WIDTH-1]};
    rem_next  = shifted_s[WIDTH-1:0];
    q_next    = {q[WIDTH-2:0], 1'b0};
    if (shifted_s >= {1'b0, divisor}) begin
      rem_next = shifted_s[WIDTH-1:0] - divisor;
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iterative.sv
// Multicycle signed divider for the MIPS datapath (DIV: lo = quotient,
// hi = remainder, truncating toward zero, remainder follows the dividend).
// Operands are reduced to magnitudes, divided by a WIDTH-step restoring loop,
// and the signs are reapplied in a single fix-up cycle.
// Optional macro DIV_EARLY_OUT_EN: when |a| < |b| the loop is skipped and the
// result (q=0, rem=|a|) goes straight to the fix-up cycle.
module div_iterative
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero_D,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_r;
  div_state_e       next_state_s;

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] mag_b_r;
  logic             sa_r;
  logic             sb_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             b_zero_s;
  logic             early_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] q_next_s;

  assign mag_a_s  = magnitude(a);
  assign mag_b_s  = magnitude(b);
  assign b_zero_s = (b == {WIDTH{1'b0}});

`ifdef DIV_EARLY_OUT_EN
  // A dividend smaller than the divisor has quotient 0 and remainder |a|.
  assign early_s = (mag_a_s < mag_b_s);
`else
  assign early_s = 1'b0;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .divisor  (mag_b_r),
    .rem_next (rem_next_s),
    .q_next   (q_next_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start requests outside IDLE are dropped.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (divControl) begin
          if (b_zero_s) begin
            next_state_s = DONE;
          end else if (early_s) begin
            next_state_s = FIX;
          end else begin
            next_state_s = RUN;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          next_state_s = FIX;
        end else begin
          next_state_s = RUN;
        end
      end
      FIX:     next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state_s == RUN) || (next_state_s == FIX);
      done <= (next_state_s == DONE);
    end
  end

  // Datapath: operand latch, restoring iterations, sign fix-up, result write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_r   <= {WIDTH{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      mag_b_r <= {WIDTH{1'b0}};
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      hi      <= {WIDTH{1'b0}};
      lo      <= {WIDTH{1'b0}};
      zero_D  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (divControl) begin
            if (b_zero_s) begin
              zero_D <= 1'b1;
            end else begin
              zero_D  <= 1'b0;
              mag_b_r <= mag_b_s;
              sa_r    <= a[WIDTH-1];
              sb_r    <= b[WIDTH-1];
              cnt_r   <= {CNT_W{1'b0}};
              if (early_s) begin
                rem_r <= mag_a_s;
                q_r   <= {WIDTH{1'b0}};
              end else begin
                rem_r <= {WIDTH{1'b0}};
                q_r   <= mag_a_s;
              end
            end
          end else begin
            zero_D <= zero_D;
          end
        end
        RUN: begin
          rem_r <= rem_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        FIX: begin
          lo <= (sa_r ^ sb_r) ? ({WIDTH{1'b0}} - q_r) : q_r;
          hi <= sa_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
        end
        DONE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iterative.sv
// Directed self-checking bench for div_iterative.
module tb_div_iterative;

  logic        clk;
  logic        reset;
  logic        divControl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        zero_D;
  logic        busy;
  logic        done;

  int checks;
  int fails;

  div_iterative dut (
    .clk        (clk),
    .reset      (reset),
    .divControl (divControl),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .zero_D     (zero_D),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start a division, wait for done, then step one cycle back to IDLE.
  // lat = edges after the start edge until done is seen; bcnt = busy cycles.
  task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output int bcnt);
    int n;
    logic overlap;
    lat = 0; bcnt = 0; overlap = 1'b0;
    a = av; b = bv; divControl = 1'b1;
    @(posedge clk); #1;
    divControl = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    checks++;
    if (!done || busy) begin
      fails++;
      $display("FAIL done_seen a=%h b=%h: done=%b busy=%b after %0d cycles, required done=1 busy=0", av, bv, done, busy, n);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse_width a=%h b=%h: done=%b, required 0", av, bv, done);
    end
  endtask

  task automatic test_reset();
    checks++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h, required 0", hi); end
    checks++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h, required 0", lo); end
    checks++; if (zero_D !== 1'b0) begin fails++; $display("FAIL reset_zero_D: got %b, required 0", zero_D); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
  endtask

  task automatic test_basic();
    int lat, bc;
    run_div(32'd7, 32'd2, lat, bc);
    checks++; if (lo !== 32'd3) begin fails++; $display("FAIL basic_lo: got %h, required 3", lo); end
    checks++; if (hi !== 32'd1) begin fails++; $display("FAIL basic_hi: got %h, required 1", hi); end
    checks++; if (zero_D !== 1'b0) begin fails++; $display("FAIL basic_zero_D: got %b, required 0", zero_D); end
    checks++; if (lat != 33) begin fails++; $display("FAIL basic_latency: got %0d, required 33", lat); end
    checks++; if (bc != 33) begin fails++; $display("FAIL basic_busy_cycles: got %0d, required 33", bc); end
  endtask

  task automatic test_signs();
    int lat, bc;
    run_div(32'hFFFFFFF9, 32'd2, lat, bc);
    checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL neg_div_lo: got %h, required FFFFFFFD", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL neg_div_hi: got %h, required FFFFFFFF", hi); end
    run_div(32'd7, 32'hFFFFFFFE, lat, bc);
    checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL neg_dsr_lo: got %h, required FFFFFFFD", lo); end
    checks++; if (hi !== 32'd1) begin fails++; $display("FAIL neg_dsr_hi: got %h, required 1", hi); end
    run_div(32'hFFFFFFF9, 32'hFFFFFFFE, lat, bc);
    checks++; if (lo !== 32'd3) begin fails++; $display("FAIL neg_both_lo: got %h, required 3", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL neg_both_hi: got %h, required FFFFFFFF", hi); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_div(32'd100, 32'd7, lat, bc);
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin fails++; $display("FAIL preload: got lo=%h hi=%h, required lo=e hi=2", lo, hi); end
    run_div(32'd5, 32'd0, lat, bc);
    checks++; if (lat != 0) begin fails++; $display("FAIL dz_latency: got %0d, required 0", lat); end
    checks++; if (bc != 0) begin fails++; $display("FAIL dz_busy: got %0d busy cycles, required 0", bc); end
    checks++; if (zero_D !== 1'b1) begin fails++; $display("FAIL dz_flag: got %b, required 1", zero_D); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin fails++; $display("FAIL dz_hold: got lo=%h hi=%h, required lo=e hi=2", lo, hi); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (zero_D !== 1'b1) begin fails++; $display("FAIL dz_flag_hold: got %b, required 1", zero_D); end
    a = 32'd9; b = 32'd3; divControl = 1'b1;
    @(posedge clk); #1;
    divControl = 1'b0;
    checks++; if (zero_D !== 1'b0) begin fails++; $display("FAIL dz_clear_at_start: got %b, required 0", zero_D); end
    repeat (40) begin
      if (!done) begin @(posedge clk); #1; end
    end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL dz_next_done: got %b, required 1", done); end
    @(posedge clk); #1;
    checks++; if (lo !== 32'd3 || hi !== 32'd0) begin fails++; $display("FAIL dz_next_result: got lo=%h hi=%h, required lo=3 hi=0", lo, hi); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    run_div(32'h80000000, 32'hFFFFFFFF, lat, bc);
    checks++; if (lo !== 32'h80000000) begin fails++; $display("FAIL ovf_lo: got %h, required 80000000", lo); end
    checks++; if (hi !== 32'h0) begin fails++; $display("FAIL ovf_hi: got %h, required 0", hi); end
    checks++; if (zero_D !== 1'b0) begin fails++; $display("FAIL ovf_zero_D: got %b, required 0", zero_D); end
    run_div(32'h80000000, 32'h80000000, lat, bc);
    checks++; if (lo !== 32'd1 || hi !== 32'h0) begin fails++; $display("FAIL min_by_min: got lo=%h hi=%h, required lo=1 hi=0", lo, hi); end
  endtask

  task automatic test_ignore_mid_run();
    int n;
    a = 32'd1000; b = 32'd3; divControl = 1'b1;
    @(posedge clk); #1;
    divControl = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    // Second start request and operand changes while running must not matter.
    a = 32'd50; b = 32'd0; divControl = 1'b1;
    @(posedge clk); #1;
    divControl = 1'b0;
    a = 32'd77; b = 32'd5;
    n = 11;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 33) begin fails++; $display("FAIL ignore_latency: got %0d, required 33", n); end
    checks++; if (lo !== 32'd333 || hi !== 32'd1) begin fails++; $display("FAIL ignore_result: got lo=%h hi=%h, required lo=14d hi=1", lo, hi); end
    checks++; if (zero_D !== 1'b0) begin fails++; $display("FAIL ignore_zero_D: got %b, required 0", zero_D); end
    @(posedge clk); #1;
  endtask

  task automatic test_early_out();
    int lat, bc;
    int exp_lat;
`ifdef DIV_EARLY_OUT_EN
    exp_lat = 1;
`else
    exp_lat = 33;
`endif
    run_div(32'd3, 32'd10, lat, bc);
    checks++; if (lo !== 32'd0 || hi !== 32'd3) begin fails++; $display("FAIL small_result: got lo=%h hi=%h, required lo=0 hi=3", lo, hi); end
    checks++; if (lat != exp_lat) begin fails++; $display("FAIL small_latency: got %0d, required %0d", lat, exp_lat); end
    run_div(32'hFFFFFFFD, 32'd10, lat, bc);
    checks++; if (lo !== 32'd0 || hi !== 32'hFFFFFFFD) begin fails++; $display("FAIL small_neg_result: got lo=%h hi=%h, required lo=0 hi=FFFFFFFD", lo, hi); end
  endtask

  task automatic test_reset_mid_run();
    a = 32'd1000; b = 32'd3; divControl = 1'b1;
    @(posedge clk); #1;
    divControl = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL midrun_reset_hilo: got lo=%h hi=%h, required 0", lo, hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrun_reset_flags: got busy=%b done=%b, required 0", busy, done); end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got lo=%h hi=%h busy=%b, required 0", lo, hi, busy); end
  endtask

  initial begin
    checks = 0; fails = 0;
    reset = 1'b0; divControl = 1'b0; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_early_out();
    test_ignore_mid_run();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/div_iterative.md
Name: div_iterative

Overview:
- Multicycle signed 32-bit divider that replaces the combinational-free div slot of the multicycle MIPS datapath.
- Operands come from registers A and B; results go to the Hi/Lo input muxes.
- Implements DIV: Lo = quotient, Hi = remainder. Division truncates toward zero, and the remainder takes the dividend's sign.
- Reports divide-by-zero to the control unit, which raises the divide-by-zero exception (handler vector 255).

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- divControl  input  1  start request from the control unit; sampled only in IDLE.
- a  input  WIDTH  dividend (register A output).
- b  input  WIDTH  divisor (register B output).
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.
- zero_D  output  1  divide-by-zero flag, registered.
- busy  output  1  high while in RUN or FIX.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi, lo, remainder/quotient work registers, counter = 0; zero_D=0; busy=0; done=0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - On an edge with divControl=1 and b==0: zero_D<=1; hi/lo hold their previous values; next state DONE.
  - On an edge with divControl=1 and b!=0: zero_D<=0; latch |a|, |b|, sa=a[31], sb=b[31]; clear work registers; counter<=0; next state RUN.
  - Otherwise stay in IDLE.
- RUN: one restoring step per edge.
  - rem = {rem[WIDTH-2:0], q[WIDTH-1]}; q shifts left.
  - If rem >= |b|: rem -= |b| and q[0]=1.
  - After WIDTH steps (counter==WIDTH-1 at the edge), go to FIX.
- FIX (one edge):
  - lo <= (sa^sb) ? -q : q.
  - hi <= sa ? -rem : rem.
  - Next state DONE.
- DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
- Latency:
  - Start edge = edge 0. RUN occupies edges 1..32. hi/lo update at edge 33. done is high between edges 33 and 34.
  - Divide-by-zero: done is high between edges 0 and 1.
- busy=1 exactly in RUN and FIX. done and busy are never both high.
- divControl while not in IDLE is ignored. It is not queued.
- Operand changes after the start edge do not affect the result (operands are latched).
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; zero_D=0; no other flag.
- Magnitude arithmetic is unsigned WIDTH bits. |0x80000000| = 0x80000000 is represented correctly.
- zero_D holds until the next accepted start.
- hi/lo hold their values indefinitely between operations.
- Reset asserted mid-RUN: immediate return to the reset values above. No partial result is written.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, a start with b!=0 and |a| < |b| bypasses RUN. The block goes straight to FIX with q=0, rem=|a|. Result: lo=0, hi=a, hi/lo updated at edge 1, done high between edges 1 and 2.
- Undefined: every nonzero-divisor operation takes the full 34-cycle latency.
- Results are identical in both builds; only timing differs.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE, RUN, FIX, DONE);
  - DIV_WIDTH=32 and DIV_CNT_W=6 constants;
  - a magnitude function (two's-complement absolute value).
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: rem, q, divisor.
  - Outputs: rem_next, q_next.
  - Instantiated once inside the RUN datapath.

Test Plan:
- a=7, b=2, start pulse -> busy for 33 cycles; done pulse; lo=3, hi=1, zero_D=0.
- a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
- Preload via a=100, b=7 (lo=14, hi=2); then a=5, b=0 -> done one cycle after start, zero_D=1, lo=14, hi=2 unchanged. Next a=9, b=3 start -> zero_D clears at the start edge; result lo=3, hi=0.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, zero_D=0.
- Start a=1000, b=3; pull reset low after 10 RUN cycles -> hi=lo=0, busy=0, done=0 immediately. A second divControl pulse issued mid-RUN in a separate run is ignored; the result stays lo=333, hi=1.
- With DIV_EARLY_OUT_EN: a=3, b=10 -> done two cycles after start, lo=0, hi=3. Without the macro: same values, done at cycle 34.
